// File: rtl/pipo_register.sv
// pipo_register: parallel-in parallel-out register built from one D flip-flop
// cell per bit. Synchronous active-high reset takes priority over load enable.
// Optional feature macro: PIPO_PARITY_EN adds a registered even-parity output
// q_par that tracks ^q in the same cycle as q.

// Per-bit storage cell: synchronous reset to its own reset bit, enable mux.
module pipo_dff_cell #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);

    // Reset wins over load; with en low the cell holds its value.
    always_ff @(posedge clk) begin
        if (rst)
            q <= RST_BIT;
        else if (en)
            q <= d;
    end

endmodule

module pipo_register #(
    parameter int              WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
`ifdef PIPO_PARITY_EN
    ,
    output logic             q_par
`endif
);

    // One independent cell per bit; no path between neighbouring bits.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pipo_dff_cell #(
            .RST_BIT (RST_VAL[i])
        ) u_cell (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .d   (d[i]),
            .q   (q[i])
        );
    end

`ifdef PIPO_PARITY_EN
    // Parity is computed from the incoming word so it lands with q, not a cycle late.
    always_ff @(posedge clk) begin
        if (rst)
            q_par <= ^RST_VAL;
        else if (en)
            q_par <= ^d;
    end
`endif

endmodule

// File: tb/tb_pipo_register.sv
// Self-checking bench for pipo_register (WIDTH=4, RST_VAL=0).
// Stimulus pushes the expected word into a queue; a monitor pops and compares
// one entry after every rising edge.
module tb_pipo_register;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] q;
        logic         par;
        logic [7:0]   tag;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] d;
    logic [W-1:0] q;
`ifdef PIPO_PARITY_EN
    logic         q_par;
`endif

    pipo_register #(
        .WIDTH   (W),
        .RST_VAL ({W{1'b0}})
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .d     (d),
        .q     (q)
`ifdef PIPO_PARITY_EN
        ,
        .q_par (q_par)
`endif
    );

    always #5 clk = ~clk;

    exp_t         sb[$];
    logic [W-1:0] model_q;
    int           vectors   = 0;
    int           miscompares = 0;
    bit           stim_done = 0;

    // Reference behaviour: the register holds one word; reset clears, load replaces.
    task automatic step_model(input logic r, input logic e, input logic [W-1:0] dv,
                              input logic [7:0] tag);
        exp_t x;
        if (r)
            model_q = '0;
        else if (e)
            model_q = dv;
        x.q   = model_q;
        x.par = ^model_q;
        x.tag = tag;
        sb.push_back(x);
    endtask

    // Drive inputs on the falling edge, then let the model predict the next edge.
    task automatic apply(input logic r, input logic e, input logic [W-1:0] dv,
                         input logic [7:0] tag);
        @(negedge clk);
        rst = r;
        en  = e;
        d   = dv;
        step_model(r, e, dv, tag);
    endtask

    // Monitor: compare one expected entry just after each rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                vectors++;
                if (q !== x.q) begin
                    miscompares++;
                    $display("FAIL q tag=%0d: got %b expected %b", x.tag, q, x.q);
                end
`ifdef PIPO_PARITY_EN
                if (q_par !== x.par) begin
                    miscompares++;
                    $display("FAIL q_par tag=%0d: got %b expected %b", x.tag, q_par, x.par);
                end
`endif
            end
        end
    end

    initial begin
        logic [W-1:0] v;
        rst = 1'b0;
        en  = 1'b0;
        d   = '0;

        // Reset with load also requested: reset must win.
        apply(1'b1, 1'b1, 4'b1010, 8'd1);
        // Load sequence.
        apply(1'b0, 1'b1, 4'b1001, 8'd2);
        apply(1'b0, 1'b1, 4'b1011, 8'd3);
        apply(1'b0, 1'b1, 4'b1111, 8'd4);
        apply(1'b0, 1'b1, 4'b1011, 8'd5);
        // Hold for three edges with different d present.
        apply(1'b0, 1'b0, 4'b0110, 8'd6);
        apply(1'b0, 1'b0, 4'b0110, 8'd7);
        apply(1'b0, 1'b0, 4'b0110, 8'd8);
        // Priority: reset over enable while holding a nonzero value.
        apply(1'b0, 1'b1, 4'b1001, 8'd9);
        apply(1'b1, 1'b1, 4'b1111, 8'd10);
        // Mid-cycle glitch on d: only the value at the edge matters.
        apply(1'b0, 1'b1, 4'b0001, 8'd11);
        #1 d = 4'b1110;
        #1 d = 4'b0001;
        // Glitch while holding: no change expected.
        apply(1'b0, 1'b0, 4'b0111, 8'd12);
        #1 d = 4'b1000;
        #1 d = 4'b0010;
        // Parity-oriented loads.
        apply(1'b0, 1'b1, 4'b1011, 8'd13);
        apply(1'b0, 1'b1, 4'b1001, 8'd14);
        // Randomized traffic, reset asserted rarely.
        for (int i = 0; i < 200; i++) begin
            v = 4'($urandom);
            apply(($urandom_range(0, 15) == 0), 1'($urandom), v, 8'd100);
        end
        stim_done = 1;
        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
